// File: rtl/vga_pkg.sv
// Shared VGA timing constants: standard-mode porch/sync widths and sync polarity
// encodings, plus the axis-length helper used to derive counter sizes.
package vga_pkg;

  localparam bit SYNC_NEG = 1'b0;
  localparam bit SYNC_POS = 1'b1;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_H_POL    = SYNC_NEG;
  localparam bit VGA640_V_POL    = SYNC_NEG;
  localparam int VGA640_H_TOTAL  = axis_total(VGA640_H_ACTIVE, VGA640_H_FRONT,
                                              VGA640_H_SYNC, VGA640_H_BACK);
  localparam int VGA640_V_TOTAL  = axis_total(VGA640_V_ACTIVE, VGA640_V_FRONT,
                                              VGA640_V_SYNC, VGA640_V_BACK);

  // 800x600@60, 40 MHz pixel clock
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FRONT  = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BACK   = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FRONT  = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BACK   = 23;
  localparam bit VGA800_H_POL    = SYNC_POS;
  localparam bit VGA800_V_POL    = SYNC_POS;

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle: pixel clock-enable in, syncs/position/strobes out.
interface vga_timing_if
  import vga_pkg::*;
#(
  parameter int HW = $clog2(VGA640_H_TOTAL),
  parameter int VW = $clog2(VGA640_V_TOTAL)
);
  logic          i_enable;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [HW-1:0] o_x;
  logic [VW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;

  modport master (
    input  i_enable,
    output o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start
  );

  modport slave (
    output i_enable,
    input  o_hsync, o_vsync, o_de, o_x, o_y, o_line_start, o_frame_start
  );
endinterface

// File: rtl/vga_axis.sv
// One raster axis: wrapping position counter plus decode of the position it
// moves to on this edge (next count, sync level, active flag) and the wrap.
module vga_axis
  import vga_pkg::*;
#(
  parameter int  ACTIVE = VGA640_H_ACTIVE,
  parameter int  FRONT  = VGA640_H_FRONT,
  parameter int  SYNC   = VGA640_H_SYNC,
  parameter int  BACK   = VGA640_H_BACK,
  parameter bit  POL    = SYNC_NEG,
  localparam int TOTAL  = axis_total(ACTIVE, FRONT, SYNC, BACK),
  localparam int W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  output logic [W-1:0] o_cnt_next,
  output logic         o_wrap,
  output logic         o_sync_next,
  output logic         o_active_next
);

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || TOTAL < 2) begin : g_bad_params
    $error("vga_axis: every timing width must be >= 1 and the total >= 2");
  end

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FRONT);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FRONT + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Reset parks the axis on its last position so the first advance lands on 0.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LAST;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt_next    = cnt_d;
  assign o_wrap        = advance && (cnt_q == LAST);
  assign o_sync_next   = ((cnt_d >= SYNC_START) && (cnt_d < SYNC_END)) ? POL : ~POL;
  assign o_active_next = (cnt_d < ACT_END);

endmodule

// File: rtl/vga_timing.sv
// Parametrised VGA raster generator: two axis counters feeding a bank of output
// registers, so every port is a flop and all outputs share one alignment.
module vga_timing
  import vga_pkg::*;
#(
  parameter int  H_ACTIVE = VGA640_H_ACTIVE,
  parameter int  H_FRONT  = VGA640_H_FRONT,
  parameter int  H_SYNC   = VGA640_H_SYNC,
  parameter int  H_BACK   = VGA640_H_BACK,
  parameter int  V_ACTIVE = VGA640_V_ACTIVE,
  parameter int  V_FRONT  = VGA640_V_FRONT,
  parameter int  V_SYNC   = VGA640_V_SYNC,
  parameter int  V_BACK   = VGA640_V_BACK,
  parameter bit  H_POL    = SYNC_NEG,
  parameter bit  V_POL    = SYNC_NEG,
  localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input logic          i_clock,
  input logic          i_reset,
  vga_timing_if.master vga
);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_sync, h_act;
  logic          v_wrap, v_sync, v_act;

  vga_axis #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_POL)
  ) u_h_axis (
    .clk(i_clock), .rst(i_reset), .advance(vga.i_enable),
    .o_cnt_next(h_cnt), .o_wrap(h_wrap), .o_sync_next(h_sync), .o_active_next(h_act)
  );

  vga_axis #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_POL)
  ) u_v_axis (
    .clk(i_clock), .rst(i_reset), .advance(vga.i_enable && h_wrap),
    .o_cnt_next(v_cnt), .o_wrap(v_wrap), .o_sync_next(v_sync), .o_active_next(v_act)
  );

  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // A wrap means the edge is moving onto x = 0 (and y = 0 for both axes); the
  // strobe registers then hold through stalls like every other output.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (vga.i_enable) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      de_d          = h_act && v_act;
      hsync_d       = h_sync;
      vsync_d       = v_sync;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      x_q           <= HW'(H_TOTAL - 1);
      y_q           <= VW'(V_TOTAL - 1);
      de_q          <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.o_x           = x_q;
  assign vga.o_y           = y_q;
  assign vga.o_de          = de_q;
  assign vga.o_hsync       = hsync_q;
  assign vga.o_vsync       = vsync_q;
  assign vga.o_line_start  = line_start_q;
  assign vga.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: default 640x480 mode and a tiny positive-polarity
// mode run side by side; a monitor checks every cycle, directed checks cover the plan.
module tb_vga_timing;
  import vga_pkg::*;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic hs, vs, de, ls, fs;
  } exp_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } mode_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  vga_timing_if #(.HW(10), .VW(10)) va ();
  vga_timing_if #(.HW(3),  .VW(3))  vb ();

  vga_timing dut_a (.i_clock(clk), .i_reset(rst_a), .vga(va));

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(SYNC_POS), .V_POL(SYNC_POS)
  ) dut_b (.i_clock(clk), .i_reset(rst_b), .vga(vb));

  exp_t  qa[$], qb[$];
  mode_t ma, mb;
  int    ax, ay, bx, by;
  int    n_tests = 0, n_fail = 0;

  // phase measurement state
  int hs_lo, hs_first, hs_last, de_cnt, de_fall, ls_first, ls_second, ls_cnt;
  int b_fs_last, b_fs_cnt, b_fs_bad, b_hs_mask, b_vs_mask, b_vs_cnt;
  int a_rise_cnt, a_rise0, a_rise1, a_ls_run;
  int b_frames, b_frame_bad, b_ls_in_frame, b_last_fs;
  bit a_ls_prev, b_ls_prev, b_fs_prev, b_started;

  function automatic exp_t decode(input mode_t m, input int x, input int y);
    exp_t e;
    int hs0, vs0;
    hs0  = m.ha + m.hf;
    vs0  = m.va + m.vf;
    e.x  = x;
    e.y  = y;
    e.de = (x < m.ha) && (y < m.va);
    e.hs = (x >= hs0 && x < hs0 + m.hs) ? m.hp : !m.hp;
    e.vs = (y >= vs0 && y < vs0 + m.vs) ? m.vp : !m.vp;
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic model_step(input mode_t m, input bit rst, input bit en,
                            inout int x, inout int y);
    int ht, vt;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    if (rst) begin
      x = ht - 1;
      y = vt - 1;
    end else if (en) begin
      if (x == ht - 1) begin
        x = 0;
        y = (y == vt - 1) ? 0 : y + 1;
      end else begin
        x = x + 1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input exp_t g);
    n_tests++;
    if (g.x !== e.x || g.y !== e.y || g.hs !== e.hs || g.vs !== e.vs ||
        g.de !== e.de || g.ls !== e.ls || g.fs !== e.fs) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               nm, $time, g.x, g.y, g.hs, g.vs, g.de, g.ls, g.fs,
               e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs);
    end
  endtask

  function automatic exp_t got_a();
    exp_t g;
    g.x = 32'(va.o_x); g.y = 32'(va.o_y);
    g.hs = va.o_hsync; g.vs = va.o_vsync; g.de = va.o_de;
    g.ls = va.o_line_start; g.fs = va.o_frame_start;
    return g;
  endfunction

  function automatic exp_t got_b();
    exp_t g;
    g.x = 32'(vb.o_x); g.y = 32'(vb.o_y);
    g.hs = vb.o_hsync; g.vs = vb.o_vsync; g.de = vb.o_de;
    g.ls = vb.o_line_start; g.fs = vb.o_frame_start;
    return g;
  endfunction

  // Drive one clock of inputs, queue what each DUT must show after that edge.
  task automatic cyc(input bit ea, input bit ra, input bit eb, input bit rb);
    va.i_enable = ea;
    rst_a       = ra;
    vb.i_enable = eb;
    rst_b       = rb;
    model_step(ma, ra, ea, ax, ay);
    qa.push_back(decode(ma, ax, ay));
    model_step(mb, rb, eb, bx, by);
    qb.push_back(decode(mb, bx, by));
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0) cmp("sb_a", qa.pop_front(), got_a());
      if (qb.size() > 0) cmp("sb_b", qb.pop_front(), got_b());
    end
  end

  initial begin
    ma = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    mb = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    ax = 0; ay = 0; bx = 0; by = 0;

    // reset held
    repeat (3) cyc(1, 1, 1, 1);
    check("a_rst_x", 32'(va.o_x), 799);
    check("a_rst_y", 32'(va.o_y), 524);
    check("a_rst_de", 32'(va.o_de), 0);
    check("a_rst_hsync", 32'(va.o_hsync), 1);
    check("a_rst_vsync", 32'(va.o_vsync), 1);
    check("a_rst_ls", 32'(va.o_line_start), 0);
    check("a_rst_fs", 32'(va.o_frame_start), 0);
    check("b_rst_x", 32'(vb.o_x), 7);
    check("b_rst_y", 32'(vb.o_y), 5);
    check("b_rst_hsync", 32'(vb.o_hsync), 0);
    check("b_rst_vsync", 32'(vb.o_vsync), 0);

    // two full default lines, enable tied high
    hs_lo = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_fall = -1;
    ls_first = -1; ls_second = -1; ls_cnt = 0;
    b_fs_last = -1; b_fs_cnt = 0; b_fs_bad = 0; b_hs_mask = 0; b_vs_mask = 0; b_vs_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      cyc(1, 0, 1, 0);
      if (i == 0) begin
        check("a_first_x", 32'(va.o_x), 0);
        check("a_first_y", 32'(va.o_y), 0);
        check("a_first_fs", 32'(va.o_frame_start), 1);
        check("a_first_ls", 32'(va.o_line_start), 1);
        check("a_first_de", 32'(va.o_de), 1);
        check("a_wrap_vsync_off", 32'(va.o_vsync), 1);
        check("b_first_fs", 32'(vb.o_frame_start), 1);
      end
      if (i < 800) begin
        if (!va.o_hsync) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(va.o_x);
          hs_last = int'(va.o_x);
        end
        if (va.o_de) de_cnt++;
        else if (de_fall < 0) de_fall = int'(va.o_x);
      end
      if (va.o_line_start) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (vb.o_frame_start) begin
        if (b_fs_last >= 0 && i - b_fs_last != 48) b_fs_bad++;
        b_fs_last = i;
        b_fs_cnt++;
      end
      if (vb.o_hsync) b_hs_mask |= (1 << vb.o_x);
      if (vb.o_vsync) begin
        b_vs_mask |= (1 << vb.o_y);
        b_vs_cnt++;
      end
    end
    check("a_hsync_low_cycles", hs_lo, 96);
    check("a_hsync_first_x", hs_first, 656);
    check("a_hsync_last_x", hs_last, 751);
    check("a_de_cycles_line", de_cnt, 640);
    check("a_de_fall_x", de_fall, 640);
    check("a_line_start_cnt", ls_cnt, 2);
    check("a_line_period", ls_second - ls_first, 800);
    check("b_frame_starts", b_fs_cnt, 34);
    check("b_frame_period_bad", b_fs_bad, 0);
    check("b_hsync_x_mask", b_hs_mask, 32'h60);
    check("b_vsync_y_mask", b_vs_mask, 32'h10);
    check("b_vsync_cycles", b_vs_cnt, 264);

    // pixel enable 1-of-4 on both DUTs
    a_rise_cnt = 0; a_rise0 = -1; a_rise1 = -1; a_ls_run = 0; a_ls_prev = 1'b0;
    b_frames = 0; b_frame_bad = 0; b_ls_in_frame = 0; b_last_fs = -1;
    b_ls_prev = 1'b0; b_fs_prev = 1'b0; b_started = 1'b0;
    for (int i = 0; i < 3204; i++) begin
      cyc(i % 4 == 0, 0, i % 4 == 0, 0);
      if (i == 2) begin
        check("a_stall_hold_x", 32'(va.o_x), 0);
        check("a_stall_hold_ls", 32'(va.o_line_start), 1);
      end
      if (va.o_line_start && !a_ls_prev) begin
        a_rise_cnt++;
        if (a_rise0 < 0) a_rise0 = i;
        else if (a_rise1 < 0) a_rise1 = i;
      end
      if (i < 3200 && va.o_line_start) a_ls_run++;
      a_ls_prev = va.o_line_start;
      if (vb.o_frame_start && !b_fs_prev) begin
        if (b_started) begin
          b_frames++;
          if (b_ls_in_frame != 6 || i - b_last_fs != 192) b_frame_bad++;
        end
        b_started = 1'b1;
        b_last_fs = i;
        b_ls_in_frame = 0;
      end
      if (vb.o_line_start && !b_ls_prev) b_ls_in_frame++;
      b_ls_prev = vb.o_line_start;
      b_fs_prev = vb.o_frame_start;
    end
    check("a_slow_line_rises", a_rise_cnt, 2);
    check("a_slow_line_clocks", a_rise1 - a_rise0, 3200);
    check("a_slow_ls_held", a_ls_run, 4);
    check("b_slow_frames", b_frames, 16);
    check("b_slow_frame_bad", b_frame_bad, 0);

    // mid-line reset, then stall, then restart
    repeat (300) cyc(1, 0, 1, 0);
    check("a_pre_rst_x", 32'(va.o_x), 300);
    check("a_pre_rst_y", 32'(va.o_y), 3);
    cyc(1, 1, 1, 0);
    check("a_mid_rst_x", 32'(va.o_x), 799);
    check("a_mid_rst_y", 32'(va.o_y), 524);
    cyc(0, 1, 1, 0);
    check("a_rst_no_en_de", 32'(va.o_de), 0);
    check("a_rst_no_en_x", 32'(va.o_x), 799);
    cyc(0, 0, 1, 0);
    check("a_post_rst_stall_x", 32'(va.o_x), 799);
    check("a_post_rst_stall_fs", 32'(va.o_frame_start), 0);
    cyc(1, 0, 1, 0);
    check("a_restart_x", 32'(va.o_x), 0);
    check("a_restart_y", 32'(va.o_y), 0);
    check("a_restart_fs", 32'(va.o_frame_start), 1);
    repeat (4) cyc(1, 0, 1, 0);

    @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised VGA raster timing generator, successor to the fixed 640-pixel horizontal sync counter. It generates both horizontal and vertical timing, pixel coordinates, a data-enable signal and line/frame start strobes for any mode described by its parameters. Sync polarity is selectable, and a pixel clock-enable allows a fast system clock. It sits between the clock source and the pixel/framebuffer logic; its outputs drive the VGA connector syncs and the pixel pipeline directly.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync asserted level
- Derived values (localparams):
  - H_TOTAL = sum of the four H parameters (800); V_TOTAL likewise (525).
  - HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- i_clock  in  1  system/pixel clock, all logic on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pixel clock-enable; tie high when i_clock is the pixel clock
- o_hsync  out  1  horizontal sync at H_POL polarity
- o_vsync  out  1  vertical sync at V_POL polarity
- o_de  out  1  high when the current position is in the visible area
- o_x  out  HW  current column, 0..H_TOTAL-1
- o_y  out  VW  current line, 0..V_TOTAL-1
- o_line_start  out  1  one-enabled-cycle strobe when o_x == 0
- o_frame_start  out  1  one-enabled-cycle strobe when o_x == 0 and o_y == 0

## Operation
- **Horizontal counter:** on each cycle with i_enable high, it advances; it wraps from H_TOTAL-1 to 0.
- **Vertical counter:** advances only on the horizontal wrap; it wraps from V_TOTAL-1 to 0.
- **Data enable:** o_de = (x < H_ACTIVE) && (y < V_ACTIVE).
- **Horizontal sync:** asserted for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751 by default).
- **Vertical sync:** asserted for V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491 by default). It changes together with the x = 0 transition and is not offset to the hsync edge.
- **Deasserted syncs** drive the logical inverse of the polarity parameter.
- **Strobes:** o_line_start and o_frame_start are high exactly while the outputs present x = 0 (respectively x = 0, y = 0). Because they are position-derived, they stay high across i_enable-low stall cycles.
- **Stall behaviour:** when i_enable is low, every output holds its value.
- **Reset:** the position is set to (H_TOTAL-1, V_TOTAL-1), which is back porch. Output values while reset is held:
  - o_x = H_TOTAL-1, o_y = V_TOTAL-1
  - o_de = 0, o_line_start = 0, o_frame_start = 0
  - both syncs deasserted
- **After reset:** the first enabled cycle presents (0,0) with o_de = 1, o_line_start = 1 and o_frame_start = 1.
- **Reset priority:** reset overrides i_enable, and reset mid-frame takes effect on the next edge regardless of position.

## Timing
- All outputs are registered. o_hsync, o_vsync, o_de and both strobes are mutually aligned with o_x/o_y in the same cycle; there is no skew between them.
- **Latency:** each enabled edge moves the presented position by exactly one pixel. This is implemented by registering outputs decoded from the next-state counter values, so no combinational path runs from the counters to the ports.
- **Frame period:** H_TOTAL × V_TOTAL enabled cycles (420000 by default). Line period: H_TOTAL enabled cycles.
- **Elaboration checks:** every width parameter must be ≥ 1, with H_TOTAL ≥ 2 and V_TOTAL ≥ 2. Violations are caught by an elaboration-time check that calls $error.

## Structure
- **Shared package vga_pkg:** per-mode timing constants (640x480@60 default, 800x600@60) and the polarity encodings SYNC_NEG = 0 and SYNC_POS = 1. Instantiating modules pass these constants as parameters.
- **Sub-module vga_axis:** one generic axis counter, parametrised by ACTIVE/FRONT/SYNC/BACK/POL.
  - Inputs: clock, reset, advance.
  - Outputs: next count, wrap, next sync, next active.
  - Instantiated twice: the horizontal axis advances on i_enable; the vertical axis advances on i_enable && h_wrap.
- **Top level:** holds the output registers and the strobe decode.

## Test plan
- **Default mode, i_enable tied high, release reset:**
  - Cycle 1 shows x = 0, y = 0, frame_start = 1 and de = 1.
  - hsync is low exactly for x = 656..751.
  - de falls at x = 640.
  - Line period is 800 cycles.
- **Full default frame:**
  - vsync is low only during lines 490–491 (1600 cycles).
  - de is high for 640×480 = 307200 cycles per frame.
  - frame_start repeats every 420000 cycles.
- **i_enable toggled 1-of-4:**
  - Outputs hold through the disabled cycles.
  - A line spans 3200 clocks.
  - Strobe counts per frame are unchanged (525 line_start, 1 frame_start).
- **Reset asserted at x = 300, y = 200 for 2 cycles:**
  - During reset, outputs equal the reset values (799, 524, de = 0).
  - The first enabled cycle after release is (0,0) with frame_start = 1.
- **Small custom mode with positive polarities** (H = 4/1/2/1, V = 3/1/1/1, H_POL = V_POL = 1):
  - hsync is high only at x = 5..6.
  - vsync is high only on y = 4.
  - Frame period is 8×6 = 48 cycles.
- **Wrap boundary:** at x = 799, y = 524 the next enabled cycle gives x = 0, y = 0 with both strobes high and vsync deasserted.
